serial_add_ctrl: RTL and testbench

Bit-serial adder/subtractor controller that time-shares a single 1-bit full-adder datapath across all bit positions of a WIDTH-bit operation. It accepts an operand pair over a valid/ready handshake and sequences the full adder LSB-first, one bit per clock, through a registered carry. It returns the WIDTH-bit result and carry-out over a second valid/ready handshake. It sits between a requester and a consumer wherever area matters more than latency.

---
 rtl/serial_add_ctrl.sv | 64 ++++++
 tb/tb_serial_add_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder/subtractor sharing one full adder, LSB first
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake carrying a, b, sub (1 = a - b)
//   out_valid/out_ready : result handshake carrying sum, cout (sub: cout = no borrow)
//   busy                : operation in flight (state not IDLE)
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] op_a, op_b;
   logic [CW-1:0] cnt;
   logic carry, s, c_nx, last;
   assign s    = op_a[0] ^ op_b[0] ^ carry;
   assign c_nx = (op_a[0] & op_b[0]) | ((op_a[0] ^ op_b[0]) & carry);
   assign last = cnt == CW'(WIDTH - 1);
   always_comb begin
      state_nx  = state == IDLE ? (in_valid ? RUN : IDLE) :
                  state == RUN  ? (last ? DONE : RUN) :
                                  (out_ready ? IDLE : DONE);
      in_ready  = state == IDLE;
      busy      = state != IDLE;
      out_valid = state == DONE;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   // Subtraction is a + ~b + 1: invert b at load and seed the carry with 1.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         op_a  <= '0;
         op_b  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         op_a  <= a;
         op_b  <= sub ? ~b : b;
         carry <= sub;
         cnt   <= '0;
      end else if (state == RUN) begin
         op_a  <= op_a >> 1;
         op_b  <= op_b >> 1;
         carry <= c_nx;
         sum   <= {s, sum[WIDTH-1:1]};
         cnt   <= cnt + 1'b1;
         if (last) cout <= c_nx;
      end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: random and directed checks of serial_add_ctrl against a transaction-level model
module tb_serial_add_ctrl;
   localparam int W = 8;
   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, sub = 1'b0, out_ready = 1'b1;
   logic [W-1:0] a = '0, b = '0;
   logic in_ready, out_valid, cout, busy;
   logic [W-1:0] sum;
   int errs = 0, checks = 0;
   always #5 clk = ~clk;
   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .busy(busy)
   );
   // Model: an accepted operation is pending for W edges, then its result is
   // presented until out_ready is seen.
   logic pend = 1'b0, m_cout = 1'b0;
   logic [W-1:0] m_sum = '0;
   int n = 0, cyc = 0, acc_cyc = 0;
   logic m_ov;
   assign m_ov = pend && n == W;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         pend <= 1'b0;
         n    <= 0;
      end else if (!pend) begin
         if (in_valid) begin
            pend    <= 1'b1;
            n       <= 0;
            acc_cyc <= cyc + 1;
            m_sum   <= sub ? W'(int'(a) - int'(b)) : W'(int'(a) + int'(b));
            m_cout  <= sub ? (a >= b) : ((int'(a) + int'(b)) >= (1 << W));
         end
      end else if (n < W) n <= n + 1;
      else if (out_ready) pend <= 1'b0;
   // Literal expectations for directed operations, pinning the model.
   logic lit_on = 1'b0, lit_cout = 1'b0, stream = 1'b0;
   logic [W-1:0] lit_sum = '0;
   logic prev_ov = 1'b0, prev_pend = 1'b0;
   int last_acc = -1;
   task automatic chk(input bit ok, input string nm, input int act, input int exp);
      checks++;
      if (!ok) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask
   always @(negedge clk) begin
      if (!rst_n) begin
         chk(sum == '0, "rst_sum", int'(sum), 0);
         chk(cout == 1'b0, "rst_cout", int'(cout), 0);
         chk(out_valid == 1'b0, "rst_out_valid", int'(out_valid), 0);
         chk(busy == 1'b0, "rst_busy", int'(busy), 0);
         chk(in_ready == 1'b1, "rst_in_ready", int'(in_ready), 1);
      end else begin
         chk(in_ready == !pend, "in_ready", int'(in_ready), int'(!pend));
         chk(busy == pend, "busy", int'(busy), int'(pend));
         chk(out_valid == m_ov, "out_valid", int'(out_valid), int'(m_ov));
         if (m_ov) begin
            chk(sum == m_sum, "sum", int'(sum), int'(m_sum));
            chk(cout == m_cout, "cout", int'(cout), int'(m_cout));
         end
         if (m_ov && !prev_ov && lit_on) begin
            chk(m_sum == lit_sum, "lit_sum", int'(m_sum), int'(lit_sum));
            chk(m_cout == lit_cout, "lit_cout", int'(m_cout), int'(lit_cout));
            chk(cyc - acc_cyc == W, "latency", cyc - acc_cyc, W);
         end
         if (pend && !prev_pend) begin
            if (stream && last_acc >= 0) chk(acc_cyc - last_acc == W + 2, "spacing", acc_cyc - last_acc, W + 2);
            last_acc = stream ? acc_cyc : -1;
         end
      end
      prev_ov   = m_ov && rst_n;
      prev_pend = pend && rst_n;
   end
   task automatic step();
      @(posedge clk);
      #2;
   endtask
   task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      a = x;
      b = y;
      sub = s;
      in_valid = 1'b1;
      for (int i = 0; i < 20 && !pend; i++) step();
      in_valid = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      sub = 1'($urandom);
   endtask
   task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      accept(x, y, s);
      for (int i = 0; i < 4 * W && pend; i++) step();
   endtask
   task automatic lit(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                      input logic [W-1:0] es, input logic ec);
      lit_on = 1'b1;
      lit_sum = es;
      lit_cout = ec;
      op(x, y, s);
      lit_on = 1'b0;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      repeat (2) @(negedge clk);
      step();
      rst_n = 1'b1;
      step();
      lit(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
      lit(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      lit(8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
      lit(8'h20, 8'h10, 1'b1, 8'h10, 1'b1);
      lit(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0);
      lit(8'h00, 8'h00, 1'b1, 8'h00, 1'b1);
      // Backpressure while inputs wiggle in DONE.
      out_ready = 1'b0;
      accept(8'hC3, 8'h4D, 1'b1);
      for (int i = 0; i < 4 * W && !m_ov; i++) step();
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'($urandom);
         a = W'($urandom);
         b = W'($urandom);
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      step();
      // Reset three cycles after accept aborts the operation.
      accept(8'h77, 8'h11, 1'b0);
      repeat (3) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      lit(8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
      // Random ops with random backpressure.
      for (int k = 0; k < 8; k++) begin
         out_ready = 1'($urandom);
         accept(W'($urandom), W'($urandom), 1'($urandom));
         for (int i = 0; i < 4 * W && !m_ov; i++) step();
         repeat ($urandom_range(0, 3)) step();
         out_ready = 1'b1;
         for (int i = 0; i < 4 && pend; i++) step();
      end
      // Back-to-back stream with in_valid and out_ready held high.
      step();
      stream = 1'b1;
      in_valid = 1'b1;
      for (int k = 0; k < 16; k++) begin
         a = W'($urandom);
         b = W'($urandom);
         sub = 1'($urandom);
         for (int i = 0; i < 20 && !pend; i++) step();
         a = W'($urandom);
         b = W'($urandom);
         sub = 1'($urandom);
         if (k == 15) in_valid = 1'b0;
         for (int i = 0; i < 4 * W && pend; i++) step();
      end
      stream = 1'b0;
      repeat (3) step();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
